// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, coordinate type and vertical phase enum.
package vga_timing_pkg;

   localparam int unsigned VGA_H_VISIBLE = 640;
   localparam int unsigned VGA_H_FRONT   = 16;
   localparam int unsigned VGA_H_SYNC    = 96;
   localparam int unsigned VGA_H_BACK    = 48;
   localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int unsigned VGA_V_VISIBLE = 480;
   localparam int unsigned VGA_V_FRONT   = 10;
   localparam int unsigned VGA_V_SYNC    = 2;
   localparam int unsigned VGA_V_BACK    = 33;
   localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

   // Vertical phase of a line index, given the first line of each blanking phase.
   function automatic v_state_t v_state_of(input coord_t v, input coord_t front_start,
                                           input coord_t sync_start, input coord_t back_start);
      if (v < front_start)     return V_ACTIVE;
      else if (v < sync_start) return V_FRONT;
      else if (v < back_start) return V_SYNC;
      else                     return V_BACK;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one VGA axis; wrap flags the last count while enabled.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL = VGA_H_TOTAL
) (
   input  logic   clr_25MHz,
   input  logic   rst,
   input  logic   en,
   output coord_t cnt,
   output logic   wrap
);

   localparam coord_t LAST = coord_t'(TOTAL - 1);

   coord_t r_cnt;

   assign wrap = en && (r_cnt == LAST);
   assign cnt  = r_cnt;

   always_ff @(posedge clr_25MHz) begin
      if (rst)       r_cnt <= '0;
      else if (wrap) r_cnt <= '0;
      else if (en)   r_cnt <= r_cnt + 10'd1;
   end

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA timing generator with vblank-only framebuffer write arbiter.
// Optional macro VGA_FRAME_COUNT_EN builds the 16-bit frame counter.
module vga_frame_scheduler #(
   parameter int unsigned H_VISIBLE = vga_timing_pkg::VGA_H_VISIBLE,
   parameter int unsigned H_FRONT   = vga_timing_pkg::VGA_H_FRONT,
   parameter int unsigned H_SYNC    = vga_timing_pkg::VGA_H_SYNC,
   parameter int unsigned H_BACK    = vga_timing_pkg::VGA_H_BACK,
   parameter int unsigned V_VISIBLE = vga_timing_pkg::VGA_V_VISIBLE,
   parameter int unsigned V_FRONT   = vga_timing_pkg::VGA_V_FRONT,
   parameter int unsigned V_SYNC    = vga_timing_pkg::VGA_V_SYNC,
   parameter int unsigned V_BACK    = vga_timing_pkg::VGA_V_BACK
) (
   input  logic        clr_25MHz,
   input  logic        rst,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        frame_start,
   input  logic        wr_req,
   output logic        wr_grant,
   output logic [15:0] frame_count
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam vga_timing_pkg::coord_t H_VIS_END = vga_timing_pkg::coord_t'(H_VISIBLE);
   localparam vga_timing_pkg::coord_t HS_FIRST  = vga_timing_pkg::coord_t'(H_VISIBLE + H_FRONT);
   localparam vga_timing_pkg::coord_t HS_LAST   = vga_timing_pkg::coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam vga_timing_pkg::coord_t V_VIS_END = vga_timing_pkg::coord_t'(V_VISIBLE);
   localparam vga_timing_pkg::coord_t VS_FIRST  = vga_timing_pkg::coord_t'(V_VISIBLE + V_FRONT);
   localparam vga_timing_pkg::coord_t VB_FIRST  = vga_timing_pkg::coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   vga_timing_pkg::coord_t   w_h_cnt, w_v_cnt;
   logic                     w_h_wrap, w_unused_v_wrap;
   vga_timing_pkg::v_state_t w_v_state;

   logic                   r_hsync, r_vsync, r_video_on, r_frame_start, r_wr_grant;
   vga_timing_pkg::coord_t r_pixel_x, r_pixel_y;

   vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
      .clr_25MHz (clr_25MHz),
      .rst       (rst),
      .en        (1'b1),
      .cnt       (w_h_cnt),
      .wrap      (w_h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
      .clr_25MHz (clr_25MHz),
      .rst       (rst),
      .en        (w_h_wrap),
      .cnt       (w_v_cnt),
      .wrap      (w_unused_v_wrap)
   );

   // The counters run one clock ahead of the outputs, so every output below is
   // decoded from the position it will show and all of them land together.
   assign w_v_state = vga_timing_pkg::v_state_of(w_v_cnt, V_VIS_END, VS_FIRST, VB_FIRST);

   always_ff @(posedge clr_25MHz) begin
      if (rst) begin
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_video_on    <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_frame_start <= 1'b0;
         r_wr_grant    <= 1'b0;
      end else begin
         r_hsync       <= !((w_h_cnt >= HS_FIRST) && (w_h_cnt <= HS_LAST));
         r_vsync       <= (w_v_state != vga_timing_pkg::V_SYNC);
         r_video_on    <= (w_h_cnt < H_VIS_END) && (w_v_cnt < V_VIS_END);
         r_pixel_x     <= w_h_cnt;
         r_pixel_y     <= w_v_cnt;
         r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
         r_wr_grant    <= wr_req && (w_v_state != vga_timing_pkg::V_ACTIVE);
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video_on;
   assign pixel_x     = r_pixel_x;
   assign pixel_y     = r_pixel_y;
   assign frame_start = r_frame_start;
   assign wr_grant    = r_wr_grant;

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] r_frame_count;

   always_ff @(posedge clr_25MHz) begin
      if (rst)                r_frame_count <= '0;
      else if (r_frame_start) r_frame_count <= r_frame_count + 16'd1;
   end

   assign frame_count = r_frame_count;
`else
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench: a full-size instance checks line timing, a shrunken one checks frame-level behaviour.
module tb_vga_frame_scheduler;

   // Shrunken timing: 32 clocks/line (hsync x=20..27), 19 lines/frame (vsync y=14..15).
   localparam int S_HTOT  = 32;
   localparam int S_FRAME = 608;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_req = 1'b0;

   logic        f_hsync, f_vsync, f_video_on, f_frame_start, f_wr_grant;
   logic [9:0]  f_pixel_x, f_pixel_y;
   logic [15:0] f_frame_count;
   logic        s_hsync, s_vsync, s_video_on, s_frame_start, s_wr_grant;
   logic [9:0]  s_pixel_x, s_pixel_y;
   logic [15:0] s_frame_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #20 clk = ~clk;

   vga_frame_scheduler u_full (
      .clr_25MHz   (clk),
      .rst         (rst),
      .hsync       (f_hsync),
      .vsync       (f_vsync),
      .video_on    (f_video_on),
      .pixel_x     (f_pixel_x),
      .pixel_y     (f_pixel_y),
      .frame_start (f_frame_start),
      .wr_req      (wr_req),
      .wr_grant    (f_wr_grant),
      .frame_count (f_frame_count)
   );

   vga_frame_scheduler #(
      .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u_small (
      .clr_25MHz   (clk),
      .rst         (rst),
      .hsync       (s_hsync),
      .vsync       (s_vsync),
      .video_on    (s_video_on),
      .pixel_x     (s_pixel_x),
      .pixel_y     (s_pixel_y),
      .frame_start (s_frame_start),
      .wr_req      (wr_req),
      .wr_grant    (s_wr_grant),
      .frame_count (s_frame_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bounded walk of the small instance to position (x,y); the final compare catches a timeout.
   task automatic wait_s(input int x, input int y, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 2 * S_FRAME && !hit; i++) begin
         if (s_pixel_x == 10'(x) && s_pixel_y == 10'(y)) hit = 1'b1;
         else step();
      end
      chk(tag, 32'({s_pixel_y, s_pixel_x}), 32'({10'(y), 10'(x)}));
   endtask

   function automatic logic [31:0] f_flags();
      return 32'({f_hsync, f_vsync, f_video_on, f_frame_start, f_wr_grant});
   endfunction

   function automatic logic [31:0] s_flags();
      return 32'({s_hsync, s_vsync, s_video_on, s_frame_start, s_wr_grant});
   endfunction

   initial begin
      int hs_lo, hs_first, hs_last, vo_cnt, x_err, y_err;
      int vs_lo, vs_first, vs_last, fs_cnt, gap, g_act, fc_bad;

      // Reset state; flags are {hsync,vsync,video_on,frame_start,wr_grant}.
      repeat (5) step();
      chk("rst_f_pos",   32'({f_pixel_y, f_pixel_x}), 0);
      chk("rst_f_flags", f_flags(), 32'b11000);
      chk("rst_f_fc",    32'(f_frame_count), 0);
      chk("rst_s_flags", s_flags(), 32'b11000);

      rst = 1'b0;
      step();
      chk("c0_f_pos",   32'({f_pixel_y, f_pixel_x}), 0);
      chk("c0_f_flags", f_flags(), 32'b11110);
      chk("c0_s_pos",   32'({s_pixel_y, s_pixel_x}), 0);
      chk("c0_s_flags", s_flags(), 32'b11110);

      // One full-size line.
      hs_lo = 0; hs_first = -1; hs_last = -1; vo_cnt = 0; x_err = 0; y_err = 0;
      for (int i = 0; i < 800; i++) begin
         if (!f_hsync) begin
            hs_lo++;
            if (hs_first < 0) hs_first = int'(f_pixel_x);
            hs_last = int'(f_pixel_x);
         end
         if (f_video_on) vo_cnt++;
         if (f_pixel_x != 10'(i)) x_err++;
         if (f_pixel_y != 10'd0) y_err++;
         step();
      end
      chk("line_hs_len",   32'(hs_lo), 96);
      chk("line_hs_first", 32'(hs_first), 656);
      chk("line_hs_last",  32'(hs_last), 751);
      chk("line_vo_len",   32'(vo_cnt), 640);
      chk("line_x_seq",    32'(x_err), 0);
      chk("line_y_hold",   32'(y_err), 0);
      chk("line_next_pos", 32'({f_pixel_y, f_pixel_x}), 32'({10'd1, 10'd0}));

      // Frame-level timing on the small instance.
      wait_s(0, 0, "frm_align");
      vs_lo = 0; vs_first = -1; vs_last = -1; fs_cnt = 0; vo_cnt = 0;
      for (int i = 0; i < S_FRAME; i++) begin
         if (!s_vsync) begin
            vs_lo++;
            if (vs_first < 0) vs_first = int'({s_pixel_y, s_pixel_x});
            vs_last = int'({s_pixel_y, s_pixel_x});
         end
         if (s_frame_start) fs_cnt++;
         if (s_video_on) vo_cnt++;
         step();
      end
      chk("frm_vs_len",   32'(vs_lo), 64);
      chk("frm_vs_first", 32'(vs_first), 32'({10'd14, 10'd0}));
      chk("frm_vs_last",  32'(vs_last), 32'({10'd15, 10'd31}));
      chk("frm_fs_once",  32'(fs_cnt), 1);
      chk("frm_vo_len",   32'(vo_cnt), 192);
      chk("frm_fs_again", 32'(s_frame_start), 1);
      gap = 0;
      do begin
         step();
         gap++;
      end while (!s_frame_start && gap < 2 * S_FRAME);
      chk("frm_fs_period", 32'(gap), S_FRAME);

      // Requests during active video are ignored; grant follows the blanking window.
      wait_s(0, 3, "arb_y3");
      wr_req = 1'b1;
      g_act = 0;
      for (int i = 0; i < S_FRAME && !(s_pixel_x == 10'd31 && s_pixel_y == 10'd11); i++) begin
         step();
         if (s_wr_grant) g_act++;
      end
      chk("arb_active_pos",  32'({s_pixel_y, s_pixel_x}), 32'({10'd11, 10'd31}));
      chk("arb_active_none", 32'(g_act), 0);
      step();
      chk("arb_blank_on",  32'(s_wr_grant), 1);
      step();
      chk("arb_blank_hold", 32'(s_wr_grant), 1);
      wait_s(S_HTOT - 1, 18, "arb_last_pos");
      chk("arb_last_line", 32'(s_wr_grant), 1);
      step();
      chk("arb_wrap_drop", 32'({s_frame_start, s_wr_grant}), 32'b10);
      wr_req = 1'b0;
      wait_s(5, 13, "arb_rise_pos");
      chk("arb_pre_rise", 32'(s_wr_grant), 0);
      wr_req = 1'b1;
      step();
      chk("arb_rise_1cyc", 32'(s_wr_grant), 1);
      wr_req = 1'b0;
      step();
      chk("arb_fall_1cyc", 32'(s_wr_grant), 0);
      wait_s(0, 5, "arb_pulse_pos");
      wr_req = 1'b1;
      step();
      step();
      wr_req = 1'b0;
      wait_s(0, 12, "arb_noq_pos");
      chk("arb_not_queued", 32'(s_wr_grant), 0);

      // Reset in the middle of vsync and hsync while a grant is held.
      wr_req = 1'b1;
      wait_s(22, 15, "rst_mid_pos");
      chk("rst_mid_before", s_flags(), 32'b00001);
      rst = 1'b1;
      step();
      chk("rst_mid_pos0",  32'({s_pixel_y, s_pixel_x}), 0);
      chk("rst_mid_flags", s_flags(), 32'b11000);
      chk("rst_mid_fc",    32'(s_frame_count), 0);
      rst = 1'b0;
      wr_req = 1'b0;
      step();
      chk("rst_rel_pos",   32'({s_pixel_y, s_pixel_x}), 0);
      chk("rst_rel_flags", s_flags(), 32'b11110);

      // Frame counter over three frames.
`ifdef VGA_FRAME_COUNT_EN
      chk("fc_c0", 32'(s_frame_count), 0);
      step();
      chk("fc_c1", 32'(s_frame_count), 1);
      repeat (3 * S_FRAME - 1) step();
      chk("fc_3frm_fs", 32'(s_frame_start), 1);
      chk("fc_3frm",    32'(s_frame_count), 3);
`else
      fc_bad = 0;
      for (int i = 0; i < 3 * S_FRAME; i++) begin
         if (s_frame_count != 16'd0 || f_frame_count != 16'd0) fc_bad++;
         step();
      end
      chk("fc_3frm_fs",  32'(s_frame_start), 1);
      chk("fc_tied_low", 32'(fc_bad), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
